// File: rtl/instruction_dispatcher_if.sv
// Host-side instruction bus: opcode/args/start going in, busy/pulses/results coming back.
// master = host (issues instructions), slave = dispatcher.
interface instruction_dispatcher_if;
  logic [7:0]  instruction;
  logic [87:0] arg_data;
  logic        instruction_start;
  logic        instruction_busy;
  logic        instruction_finished;
  logic        instruction_error;
  logic [7:0]  result_0;
  logic [7:0]  result_1;

  modport master (
    output instruction, arg_data, instruction_start,
    input  instruction_busy, instruction_finished, instruction_error, result_0, result_1
  );

  modport slave (
    input  instruction, arg_data, instruction_start,
    output instruction_busy, instruction_finished, instruction_error, result_0, result_1
  );
endinterface

// File: rtl/instruction_dispatcher.sv
// Decodes a host opcode, starts one of three engines (text/gfx/pal) and reports its
// completion, error or timeout back to the host as single-cycle pulses.
//
// state  | meaning
// IDLE   | waiting for instruction_start
// WAIT   | selected engine started, watching its done and the timeout counter
// ERR    | opcode was invalid, error pulse follows on the next edge
// DONE   | finish/error pulse cycle; starts are ignored until IDLE next cycle
module instruction_dispatcher #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic                    phi2,
  input  logic                    reset,
  instruction_dispatcher_if.slave host,
  output logic [7:0]              cmd_opcode,
  output logic [87:0]             cmd_args,
  output logic                    text_start,
  output logic                    gfx_start,
  output logic                    pal_start,
  input  logic                    text_done,
  input  logic                    gfx_done,
  input  logic                    pal_done,
  input  logic                    text_err,
  input  logic                    gfx_err,
  input  logic                    pal_err,
  input  logic [15:0]             text_result,
  input  logic [15:0]             gfx_result,
  input  logic [15:0]             pal_result
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR, S_DONE} state_t;
  typedef enum logic [1:0] {ENG_TEXT, ENG_GFX, ENG_PAL, ENG_NONE} eng_t;

  state_t      state, state_nxt;
  eng_t        sel, sel_nxt, dec_eng;
  logic [15:0] cnt, cnt_nxt;
  logic        busy, busy_nxt;
  logic        fin, fin_nxt;
  logic        err, err_nxt;
  logic [2:0]  starts, starts_nxt;
  logic [7:0]  res0, res0_nxt, res1, res1_nxt;
  logic [7:0]  opc_nxt;
  logic [87:0] args_nxt;
  logic        sel_done, sel_err;
  logic [15:0] sel_result;

  always_comb begin
    dec_eng = ENG_NONE;
    if (host.instruction <= 8'h04)
      dec_eng = ENG_TEXT;
    else if (host.instruction >= 8'h10 && host.instruction <= 8'h14)
      dec_eng = ENG_GFX;
    else if (host.instruction == 8'h20 || host.instruction == 8'h21)
      dec_eng = ENG_PAL;
  end

  // Only the engine that was started is observed; the others can pulse freely.
  always_comb begin
    sel_done   = 1'b0;
    sel_err    = 1'b0;
    sel_result = 16'h0000;
    case (sel)
      ENG_TEXT: begin sel_done = text_done; sel_err = text_err; sel_result = text_result; end
      ENG_GFX:  begin sel_done = gfx_done;  sel_err = gfx_err;  sel_result = gfx_result;  end
      ENG_PAL:  begin sel_done = pal_done;  sel_err = pal_err;  sel_result = pal_result;  end
      default:  ;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel;
    cnt_nxt    = cnt;
    busy_nxt   = busy;
    fin_nxt    = 1'b0;
    err_nxt    = 1'b0;
    starts_nxt = 3'b000;
    res0_nxt   = res0;
    res1_nxt   = res1;
    opc_nxt    = cmd_opcode;
    args_nxt   = cmd_args;
    case (state)
      S_IDLE: begin
        if (host.instruction_start) begin
          opc_nxt  = host.instruction;
          args_nxt = host.arg_data;
          busy_nxt = 1'b1;
          sel_nxt  = dec_eng;
          cnt_nxt  = 16'h0000;
          case (dec_eng)
            ENG_TEXT: starts_nxt = 3'b001;
            ENG_GFX:  starts_nxt = 3'b010;
            ENG_PAL:  starts_nxt = 3'b100;
            default:  starts_nxt = 3'b000;
          endcase
          state_nxt = (dec_eng == ENG_NONE) ? S_ERR : S_WAIT;
        end
      end
      S_WAIT: begin
        // done is checked first so it beats a coincident timeout
        if (sel_done) begin
          busy_nxt  = 1'b0;
          state_nxt = S_DONE;
          if (sel_err) begin
            err_nxt = 1'b1;
          end else begin
            fin_nxt  = 1'b1;
            res0_nxt = sel_result[7:0];
            res1_nxt = sel_result[15:8];
          end
        end else if (cnt == TIMEOUT_CYCLES - 16'd1) begin
          err_nxt   = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      S_ERR: begin
        err_nxt   = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge phi2) begin
    if (reset) begin
      state      <= S_IDLE;
      sel        <= ENG_NONE;
      cnt        <= 16'h0000;
      busy       <= 1'b0;
      fin        <= 1'b0;
      err        <= 1'b0;
      starts     <= 3'b000;
      res0       <= 8'h00;
      res1       <= 8'h00;
      cmd_opcode <= 8'h00;
      cmd_args   <= '0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      cnt        <= cnt_nxt;
      busy       <= busy_nxt;
      fin        <= fin_nxt;
      err        <= err_nxt;
      starts     <= starts_nxt;
      res0       <= res0_nxt;
      res1       <= res1_nxt;
      cmd_opcode <= opc_nxt;
      cmd_args   <= args_nxt;
    end
  end

  assign host.instruction_busy     = busy;
  assign host.instruction_finished = fin;
  assign host.instruction_error    = err;
  assign host.result_0             = res0;
  assign host.result_1             = res1;
  assign text_start                = starts[0];
  assign gfx_start                 = starts[1];
  assign pal_start                 = starts[2];

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Directed bench for instruction_dispatcher with TIMEOUT_CYCLES=8; inputs change and
// outputs are checked on the falling edge of phi2.
module tb_instruction_dispatcher;
  logic        phi2 = 1'b0;
  logic        reset;
  logic [7:0]  cmd_opcode;
  logic [87:0] cmd_args;
  logic        text_start, gfx_start, pal_start;
  logic        text_done, gfx_done, pal_done;
  logic        text_err, gfx_err, pal_err;
  logic [15:0] text_result, gfx_result, pal_result;
  logic [5:0]  flags;
  int          checks = 0;
  int          errors = 0;

  instruction_dispatcher_if hif();

  instruction_dispatcher #(.TIMEOUT_CYCLES(16'd8)) dut (
    .phi2(phi2), .reset(reset), .host(hif),
    .cmd_opcode(cmd_opcode), .cmd_args(cmd_args),
    .text_start(text_start), .gfx_start(gfx_start), .pal_start(pal_start),
    .text_done(text_done), .gfx_done(gfx_done), .pal_done(pal_done),
    .text_err(text_err), .gfx_err(gfx_err), .pal_err(pal_err),
    .text_result(text_result), .gfx_result(gfx_result), .pal_result(pal_result)
  );

  always #5 phi2 = ~phi2;

  // {busy, finished, error, text_start, gfx_start, pal_start}
  assign flags = {hif.instruction_busy, hif.instruction_finished, hif.instruction_error,
                  text_start, gfx_start, pal_start};

  always @(negedge phi2) begin
    if (hif.instruction_finished && hif.instruction_error) begin
      errors++;
      $display("FAIL excl_pulses: finished and error both high at %0t", $time);
    end
  end

  task automatic tick();
    @(negedge phi2);
  endtask

  task automatic start_instr(input logic [7:0] opc, input logic [87:0] args);
    hif.instruction       = opc;
    hif.arg_data          = args;
    hif.instruction_start = 1'b1;
    tick();
    hif.instruction_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (flags !== 6'b000000) begin errors++; $display("FAIL reset_flags: got %b want %b", flags, 6'b000000); end
    checks++;
    if ({hif.result_1, hif.result_0, cmd_opcode} !== 24'h000000) begin
      errors++; $display("FAIL reset_regs: got %h want %h", {hif.result_1, hif.result_0, cmd_opcode}, 24'h000000);
    end
    checks++;
    if (cmd_args !== 88'h0) begin errors++; $display("FAIL reset_args: got %h want 0", cmd_args); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_gfx_success();
    start_instr(8'h12, 88'h0102_0304_0506_0708_09AB_34);          // now in S+1
    checks++;
    if (flags !== 6'b100010) begin errors++; $display("FAIL gfx_s1_flags: got %b want %b", flags, 6'b100010); end
    checks++;
    if (cmd_opcode !== 8'h12) begin errors++; $display("FAIL gfx_opcode: got %h want 12", cmd_opcode); end
    checks++;
    if (cmd_args[7:0] !== 8'h34 || cmd_args !== 88'h0102_0304_0506_0708_09AB_34) begin
      errors++; $display("FAIL gfx_args: got %h want 0102030405060708 09ab34", cmd_args);
    end
    tick();                                                        // S+2
    checks++;
    if (flags !== 6'b100000) begin errors++; $display("FAIL gfx_s2_flags: got %b want %b", flags, 6'b100000); end
    tick();                                                        // S+3
    gfx_done = 1'b1; gfx_result = 16'hBEEF;
    tick();                                                        // S+4
    gfx_done = 1'b0; gfx_result = 16'h0000;
    checks++;
    if (flags !== 6'b010000) begin errors++; $display("FAIL gfx_finish_flags: got %b want %b", flags, 6'b010000); end
    checks++;
    if ({hif.result_1, hif.result_0} !== 16'hBEEF) begin
      errors++; $display("FAIL gfx_result: got %h want beef", {hif.result_1, hif.result_0});
    end
    tick();
    checks++;
    if (flags !== 6'b000000) begin errors++; $display("FAIL gfx_after_flags: got %b want %b", flags, 6'b000000); end
  endtask

  task automatic test_invalid_opcode();
    start_instr(8'h05, 88'h0);                                     // S+1
    checks++;
    if (flags !== 6'b100000) begin errors++; $display("FAIL inv_s1_flags: got %b want %b", flags, 6'b100000); end
    tick();                                                        // S+2
    checks++;
    if (flags !== 6'b001000) begin errors++; $display("FAIL inv_s2_flags: got %b want %b", flags, 6'b001000); end
    checks++;
    if ({hif.result_1, hif.result_0, cmd_opcode} !== 24'hBEEF05) begin
      errors++; $display("FAIL inv_regs: got %h want beef05", {hif.result_1, hif.result_0, cmd_opcode});
    end
    tick();
    checks++;
    if (flags !== 6'b000000) begin errors++; $display("FAIL inv_after_flags: got %b want %b", flags, 6'b000000); end
  endtask

  task automatic test_pal_error();
    start_instr(8'h20, 88'h0);                                     // S+1
    checks++;
    if (flags !== 6'b100001) begin errors++; $display("FAIL pal_s1_flags: got %b want %b", flags, 6'b100001); end
    pal_done = 1'b1; pal_err = 1'b1; pal_result = 16'h1234;
    tick();                                                        // S+2
    pal_done = 1'b0; pal_err = 1'b0; pal_result = 16'h0000;
    checks++;
    if (flags !== 6'b001000) begin errors++; $display("FAIL pal_err_flags: got %b want %b", flags, 6'b001000); end
    checks++;
    if ({hif.result_1, hif.result_0} !== 16'hBEEF) begin
      errors++; $display("FAIL pal_result_kept: got %h want beef", {hif.result_1, hif.result_0});
    end
    tick();
  endtask

  task automatic test_timeout();
    start_instr(8'h00, 88'h0);                                     // S+1, first WAIT cycle
    checks++;
    if (flags !== 6'b100100) begin errors++; $display("FAIL to_s1_flags: got %b want %b", flags, 6'b100100); end
    repeat (7) tick();                                             // S+8, last WAIT cycle
    checks++;
    if (flags !== 6'b100000) begin errors++; $display("FAIL to_s8_flags: got %b want %b", flags, 6'b100000); end
    tick();                                                        // S+9
    checks++;
    if (flags !== 6'b001000) begin errors++; $display("FAIL to_err_flags: got %b want %b", flags, 6'b001000); end
    tick();                                                        // back in IDLE
    start_instr(8'h00, 88'h0);                                     // S'+1
    repeat (7) tick();                                             // S'+8
    text_done = 1'b1; text_result = 16'h5AA5;
    tick();                                                        // S'+9, pulse cycle
    text_done = 1'b0; text_result = 16'h0000;
    checks++;
    if (flags !== 6'b010000) begin errors++; $display("FAIL to_done_wins: got %b want %b", flags, 6'b010000); end
    checks++;
    if ({hif.result_1, hif.result_0} !== 16'h5AA5) begin
      errors++; $display("FAIL to_result: got %h want 5aa5", {hif.result_1, hif.result_0});
    end
    start_instr(8'h10, 88'hFF);                                    // start during pulse cycle
    checks++;
    if (flags !== 6'b000000) begin errors++; $display("FAIL pulse_start_ignored: got %b want %b", flags, 6'b000000); end
    checks++;
    if (cmd_opcode !== 8'h00) begin errors++; $display("FAIL pulse_start_opcode: got %h want 00", cmd_opcode); end
    tick();
  endtask

  task automatic test_back_to_back();
    start_instr(8'h03, 88'h0);                                     // S+1
    checks++;
    if (flags !== 6'b100100) begin errors++; $display("FAIL b2b_s1_flags: got %b want %b", flags, 6'b100100); end
    hif.instruction = 8'h13; hif.instruction_start = 1'b1;
    gfx_done = 1'b1; gfx_err = 1'b1; gfx_result = 16'h9999;
    tick();                                                        // S+2
    hif.instruction_start = 1'b0;
    checks++;
    if (flags !== 6'b100000) begin errors++; $display("FAIL b2b_s2_flags: got %b want %b", flags, 6'b100000); end
    checks++;
    if (cmd_opcode !== 8'h03) begin errors++; $display("FAIL b2b_opcode: got %h want 03", cmd_opcode); end
    text_done = 1'b1; text_result = 16'h3C4D;
    gfx_done = 1'b1; gfx_err = 1'b0; gfx_result = 16'h2222;
    tick();                                                        // S+3
    text_done = 1'b0; text_result = 16'h0000;
    gfx_done = 1'b0; gfx_result = 16'h0000;
    checks++;
    if (flags !== 6'b010000) begin errors++; $display("FAIL b2b_finish_flags: got %b want %b", flags, 6'b010000); end
    checks++;
    if ({hif.result_1, hif.result_0, cmd_opcode} !== 24'h3C4D03) begin
      errors++; $display("FAIL b2b_regs: got %h want 3c4d03", {hif.result_1, hif.result_0, cmd_opcode});
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    start_instr(8'h01, 88'h55);                                    // S+1
    checks++;
    if (flags !== 6'b100100) begin errors++; $display("FAIL rst_s1_flags: got %b want %b", flags, 6'b100100); end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (flags !== 6'b000000) begin errors++; $display("FAIL rst_flags: got %b want %b", flags, 6'b000000); end
    checks++;
    if ({hif.result_1, hif.result_0, cmd_opcode} !== 24'h000000 || cmd_args !== 88'h0) begin
      errors++; $display("FAIL rst_regs: got %h/%h want 0", {hif.result_1, hif.result_0, cmd_opcode}, cmd_args);
    end
    text_done = 1'b1; text_result = 16'hFFFF;
    tick();
    text_done = 1'b0; text_result = 16'h0000;
    tick();
    checks++;
    if (flags !== 6'b000000 || {hif.result_1, hif.result_0} !== 16'h0000) begin
      errors++; $display("FAIL rst_late_done: got %b/%h want 000000/0000", flags, {hif.result_1, hif.result_0});
    end
    start_instr(8'h14, 88'h0);
    checks++;
    if (flags !== 6'b100010) begin errors++; $display("FAIL rst_idle_start: got %b want %b", flags, 6'b100010); end
    gfx_done = 1'b1; gfx_result = 16'h0102;
    tick();
    gfx_done = 1'b0; gfx_result = 16'h0000;
    checks++;
    if ({flags, hif.result_1, hif.result_0} !== {6'b010000, 16'h0102}) begin
      errors++; $display("FAIL rst_recover: got %b/%h want 010000/0102", flags, {hif.result_1, hif.result_0});
    end
    tick();
  endtask

  initial begin
    reset = 1'b1;
    hif.instruction = 8'h00; hif.arg_data = '0; hif.instruction_start = 1'b0;
    text_done = 1'b0; gfx_done = 1'b0; pal_done = 1'b0;
    text_err = 1'b0; gfx_err = 1'b0; pal_err = 1'b0;
    text_result = 16'h0000; gfx_result = 16'h0000; pal_result = 16'h0000;
    test_reset();
    test_gfx_success();
    test_invalid_opcode();
    test_pal_error();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
